// File: rtl/grid_turn_scheduler.sv
// grid_turn_scheduler
// Owns the backtracking cursor for the grid search. The turn goes to one tile
// at a time, and given (pre-filled) tiles are stepped over one per cycle. The
// cursor moves forward or back on each tile's report. The scheduler ends in
// DONE_OK when it walks off the last tile and in DONE_FAIL when it backs off
// tile 0. A watchdog on the number of grants can also end a run in DONE_FAIL.
module grid_turn_scheduler #(
    parameter int ORDER      = 3,
    parameter int MAX_GRANTS = 0,
    localparam int LENGTH    = ORDER * ORDER,
    localparam int AREA      = LENGTH * LENGTH,
    localparam int CW        = $clog2(AREA)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [AREA-1:0] given_mask,
    input  logic            tile_done,
    input  logic            tile_pass_back,
    output logic [CW-1:0]   cursor,
    output logic            turn_valid,
    output logic            turn_from_back,
    output logic            busy,
    output logic            done_success,
    output logic            done_failure,
    output logic            timed_out,
    output logic [31:0]     grant_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEK,
        ST_GRANT,
        ST_WAIT,
        ST_DONE_OK,
        ST_DONE_FAIL
    } state_t;

    localparam logic [CW-1:0] LAST_TILE   = CW'(AREA - 1);
    localparam logic [CW-1:0] FIRST_TILE  = '0;
    localparam logic [31:0]   GRANT_LIMIT = 32'(MAX_GRANTS);
    localparam bit            WATCHDOG_ON = (MAX_GRANTS != 0);

    state_t        state_reg, state_next;
    logic [CW-1:0] cursor_reg, cursor_next;
    logic          dir_back_reg, dir_back_next;     // 1 = cursor is retreating
    logic [31:0]   grant_count_reg, grant_count_next;
    logic          timed_out_reg, timed_out_next;

    logic [31:0]   grant_count_inc;
    logic          cursor_given;
    logic          at_last;
    logic          at_first;
    logic          launch;

    // Helper terms shared by the next-state logic
    always_comb begin
        grant_count_inc = (&grant_count_reg) ? grant_count_reg
                                             : grant_count_reg + 32'd1;
        cursor_given    = given_mask[cursor_reg];
        at_last         = (cursor_reg == LAST_TILE);
        at_first        = (cursor_reg == FIRST_TILE);
        launch          = start && (state_reg == ST_IDLE ||
                                    state_reg == ST_DONE_OK ||
                                    state_reg == ST_DONE_FAIL);
    end

    // State and datapath registers; reset wins over every other input
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            cursor_reg      <= '0;
            dir_back_reg    <= 1'b0;
            grant_count_reg <= '0;
            timed_out_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cursor_reg      <= cursor_next;
            dir_back_reg    <= dir_back_next;
            grant_count_reg <= grant_count_next;
            timed_out_reg   <= timed_out_next;
        end
    end

    // Next-state logic: seek past given tiles, grant, wait for the tile's report
    always_comb begin
        state_next       = state_reg;
        cursor_next      = cursor_reg;
        dir_back_next    = dir_back_reg;
        grant_count_next = grant_count_reg;
        timed_out_next   = timed_out_reg;

        if (launch) begin
            // Start from IDLE or from either DONE state behaves the same way
            state_next       = ST_SEEK;
            cursor_next      = '0;
            dir_back_next    = 1'b0;
            grant_count_next = '0;
            timed_out_next   = 1'b0;
        end else begin
            unique case (state_reg)
                ST_SEEK: begin
                    if (!cursor_given) begin
                        state_next = ST_GRANT;
                    end else if (!dir_back_reg) begin
                        if (at_last) begin
                            state_next = ST_DONE_OK;
                        end else begin
                            cursor_next = cursor_reg + CW'(1);
                        end
                    end else begin
                        if (at_first) begin
                            state_next = ST_DONE_FAIL;
                        end else begin
                            cursor_next = cursor_reg - CW'(1);
                        end
                    end
                end
                ST_GRANT: begin
                    grant_count_next = grant_count_inc;
                    if (WATCHDOG_ON && grant_count_inc == GRANT_LIMIT) begin
                        state_next     = ST_DONE_FAIL;
                        timed_out_next = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (tile_done) begin
                        if (!tile_pass_back) begin
                            if (at_last) begin
                                state_next = ST_DONE_OK;
                            end else begin
                                cursor_next   = cursor_reg + CW'(1);
                                dir_back_next = 1'b0;
                                state_next    = ST_SEEK;
                            end
                        end else begin
                            if (at_first) begin
                                state_next = ST_DONE_FAIL;
                            end else begin
                                cursor_next   = cursor_reg - CW'(1);
                                dir_back_next = 1'b1;
                                state_next    = ST_SEEK;
                            end
                        end
                    end
                end
                default: begin
                    // IDLE and DONE states hold everything until start
                end
            endcase
        end
    end

    // Outputs decoded directly from the state so they cannot overlap
    always_comb begin
        cursor         = cursor_reg;
        turn_valid     = (state_reg == ST_GRANT);
        turn_from_back = (state_reg == ST_GRANT) && dir_back_reg;
        busy           = (state_reg == ST_SEEK) || (state_reg == ST_GRANT) ||
                         (state_reg == ST_WAIT);
        done_success   = (state_reg == ST_DONE_OK);
        done_failure   = (state_reg == ST_DONE_FAIL);
        timed_out      = (state_reg == ST_DONE_FAIL) && timed_out_reg;
        grant_count    = grant_count_reg;
    end

endmodule

// File: tb/tb_grid_turn_scheduler.sv
// Testbench for grid_turn_scheduler (ORDER=2, 16 tiles, watchdog at 40 grants).
// A transaction-level model walks the mask and the responses to predict each
// grant (cursor, direction, latency) and the final outcome of every run.
module tb_grid_turn_scheduler;

    localparam int ORDER      = 2;
    localparam int MAX_GRANTS = 40;
    localparam int AREA       = 16;
    localparam int CW         = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [AREA-1:0] given_mask = '0;
    logic            tile_done = 1'b0;
    logic            tile_pass_back = 1'b0;
    logic [CW-1:0]   cursor;
    logic            turn_valid;
    logic            turn_from_back;
    logic            busy;
    logic            done_success;
    logic            done_failure;
    logic            timed_out;
    logic [31:0]     grant_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    grid_turn_scheduler #(
        .ORDER      (ORDER),
        .MAX_GRANTS (MAX_GRANTS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .given_mask     (given_mask),
        .tile_done      (tile_done),
        .tile_pass_back (tile_pass_back),
        .cursor         (cursor),
        .turn_valid     (turn_valid),
        .turn_from_back (turn_from_back),
        .busy           (busy),
        .done_success   (done_success),
        .done_failure   (done_failure),
        .timed_out      (timed_out),
        .grant_count    (grant_count)
    );

    task automatic check_value(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Outputs sampled on the falling edge, inputs changed right after it
    always @(negedge clock) begin
        if (!reset) begin
            check_value("done_exclusive", 64'(done_success & done_failure), 64'd0);
            check_value("turn_needs_busy", 64'(turn_valid & ~busy), 64'd0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_cursor"}, 64'(cursor), 64'd0);
        check_value({tag, "_turn_valid"}, 64'(turn_valid), 64'd0);
        check_value({tag, "_from_back"}, 64'(turn_from_back), 64'd0);
        check_value({tag, "_busy"}, 64'(busy), 64'd0);
        check_value({tag, "_done_ok"}, 64'(done_success), 64'd0);
        check_value({tag, "_done_fail"}, 64'(done_failure), 64'd0);
        check_value({tag, "_timed_out"}, 64'(timed_out), 64'd0);
        check_value({tag, "_grant_count"}, 64'(grant_count), 64'd0);
    endtask

    // mode: 0 always forward, 1 random (30% back), 2 back only on tile 1,
    // 3 back on tile 2 and on tile 0 when re-entered from behind.
    // abort_at >= 0 asserts reset while waiting on that tile.
    task automatic run_search(input int run_id, input logic [AREA-1:0] mask,
                              input int mode, input int abort_at);
        int  cur;
        bit  back;
        int  grants;
        int  steps;
        int  outcome;   // 0 running, 1 success, 2 failure, 3 watchdog
        int  done_wait;
        int  waited;
        bit  pb;

        given_mask = mask;
        start      = 1'b1;
        tile_done  = 1'($urandom);
        tick();
        start     = 1'b0;
        tile_done = 1'b0;
        check_value("start_busy", 64'(busy), 64'd1);
        check_value("start_cursor", 64'(cursor), 64'd0);
        check_value("start_grant_count", 64'(grant_count), 64'd0);
        check_value("start_done_ok", 64'(done_success), 64'd0);
        check_value("start_done_fail", 64'(done_failure), 64'd0);

        cur = 0; back = 1'b0; grants = 0; outcome = 0; done_wait = 0;
        while (outcome == 0) begin
            // Walk over given tiles exactly as the search rules say
            steps = 0;
            while (mask[cur] && outcome == 0) begin
                steps++;
                if (!back) begin
                    if (cur == AREA - 1) outcome = 1;
                    else cur++;
                end else begin
                    if (cur == 0) outcome = 2;
                    else cur--;
                end
            end
            if (outcome != 0) begin
                done_wait = steps;
            end else begin
                waited = 0;
                do begin
                    tile_done = 1'($urandom);
                    start     = 1'($urandom);
                    tick();
                    waited++;
                end while (turn_valid !== 1'b1 && waited < 64);
                tile_done = 1'b0;
                start     = 1'b0;
                check_value("grant_latency", 64'(waited), 64'(steps + 1));
                check_value("grant_cursor", 64'(cursor), 64'(cur));
                check_value("grant_from_back", 64'(turn_from_back), 64'(back));
                grants++;
                if (grants == MAX_GRANTS) begin
                    outcome   = 3;
                    done_wait = 1;
                end else begin
                    // The cycle of the grant: a report here must be ignored
                    tile_done = 1'($urandom);
                    start     = 1'($urandom);
                    tick();
                    tile_done = 1'b0;
                    check_value("turn_one_cycle", 64'(turn_valid), 64'd0);
                    check_value("wait_grant_count", 64'(grant_count), 64'(grants));
                    repeat ($urandom_range(0, 2)) begin
                        start = 1'($urandom);
                        tick();
                        check_value("wait_cursor_held", 64'(cursor), 64'(cur));
                    end
                    if (cur == abort_at) begin
                        reset     = 1'b1;
                        tile_done = 1'b1;
                        start     = 1'b0;
                        tick();
                        reset     = 1'b0;
                        tile_done = 1'b0;
                        check_reset_outputs("abort");
                        $display("run %0d mask %h mode %0d: reset at cursor %0d after %0d grants",
                                 run_id, mask, mode, cur, grants);
                        return;
                    end
                    case (mode)
                        0:       pb = 1'b0;
                        1:       pb = ($urandom_range(0, 99) < 30);
                        2:       pb = (cur == 1);
                        default: pb = (cur == 2) || (cur == 0 && back);
                    endcase
                    tile_done      = 1'b1;
                    tile_pass_back = pb;
                    start          = 1'($urandom);
                    tick();
                    tile_done      = 1'b0;
                    start          = 1'b0;
                    tile_pass_back = 1'($urandom);
                    if (!pb) begin
                        if (cur == AREA - 1) outcome = 1;
                        else begin cur++; back = 1'b0; end
                    end else begin
                        if (cur == 0) outcome = 2;
                        else begin cur--; back = 1'b1; end
                    end
                    done_wait = 0;
                end
            end
        end

        waited = 0;
        while (!(done_success === 1'b1 || done_failure === 1'b1) && waited < 64) begin
            tile_done = 1'($urandom);
            tick();
            waited++;
        end
        tile_done = 1'b0;
        check_value("done_latency", 64'(waited), 64'(done_wait));
        check_value("done_ok", 64'(done_success), 64'(outcome == 1));
        check_value("done_fail", 64'(done_failure), 64'(outcome != 1));
        check_value("done_timed_out", 64'(timed_out), 64'(outcome == 3));
        check_value("done_grant_count", 64'(grant_count), 64'(grants));
        check_value("done_cursor", 64'(cursor), 64'(cur));
        check_value("done_busy", 64'(busy), 64'd0);
        // Flags and cursor hold while idle in DONE, even with stray reports
        repeat (2) begin
            tile_done = 1'($urandom);
            tick();
        end
        tile_done = 1'b0;
        check_value("hold_cursor", 64'(cursor), 64'(cur));
        check_value("hold_done", 64'(done_success | done_failure), 64'd1);
        $display("run %0d mask %h mode %0d: outcome %0d, %0d grants, cursor %0d",
                 run_id, mask, mode, outcome, grants, cur);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [AREA-1:0] rmask;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_outputs("reset");

        // Stray reports while idle leave the scheduler alone
        tile_done = 1'b1;
        tick();
        tile_done = 1'b0;
        tick();
        check_value("idle_busy", 64'(busy), 64'd0);
        check_value("idle_cursor", 64'(cursor), 64'd0);

        run_search(1, 16'h0000, 0, -1);   // all forward, success
        run_search(2, 16'hFFFF, 0, -1);   // everything given, start from DONE_OK
        run_search(3, 16'h0002, 3, -1);   // backtrack over a given tile, failure
        run_search(4, 16'h0000, 2, -1);   // ping-pong until the watchdog fires
        run_search(5, 16'h0000, 0, 7);    // reset while waiting on tile 7
        run_search(6, 16'h0000, 0, -1);   // clean run from IDLE after the reset
        for (int i = 0; i < 24; i++) begin
            rmask = 16'($urandom) & 16'($urandom);
            run_search(10 + i, rmask, 1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grid_turn_scheduler.md
Name: grid_turn_scheduler

Overview:
- Sequences the backtracking search across the grid's tiles by owning the "cursor", the one tile that currently holds the turn.
- Grants the turn to one tile at a time and skips given (pre-filled) tiles.
- Advances or retreats the cursor on each tile's pass-forward/pass-back report.
- Raises done_success or done_failure for the top-level status display. Sits inside grid, between the start key and the tile array.

Parameters:
ORDER, 3, sub-block side; LENGTH = ORDER*ORDER, AREA = LENGTH*LENGTH (81 at default)
MAX_GRANTS, 0, watchdog limit on turn grants per run; 0 disables the watchdog
CW, $clog2(AREA), cursor index width (derived; not overridden)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; one clock, all state sampled on rising edge of clock
start  in  1  level; begins a run from IDLE or from either DONE state
given_mask  in  AREA  bit i = 1 means tile i is pre-filled and is never granted; sampled every SEEK cycle, must be stable during a run
tile_done  in  1  one-cycle report from the cursor tile; honoured only in WAIT
tile_pass_back  in  1  qualifies tile_done; 1 = tile exhausted its values (go back), 0 = tile placed a value (go forward)
cursor  out  CW  index of the tile holding or about to receive the turn (row-major, 0..AREA-1)
turn_valid  out  1  one-cycle pulse granting the turn to tile[cursor]
turn_from_back  out  1  valid with turn_valid; 1 = turn arrived by backtracking (tile must try its next value), 0 = fresh entry (tile starts from its lowest candidate)
busy  out  1  high in SEEK/GRANT/WAIT
done_success  out  1  level, high in DONE_OK
done_failure  out  1  level, high in DONE_FAIL
timed_out  out  1  level, high in DONE_FAIL when entered via watchdog
grant_count  out  32  turns granted this run, saturating at 2^32-1

Behaviour:
- Reset (synchronous, overrides everything, including mid-run): state IDLE, cursor 0, dir FWD, turn_valid 0, turn_from_back 0, busy 0, done_success 0, done_failure 0, timed_out 0, grant_count 0.
- IDLE:
  - start=1 -> cursor 0, dir FWD, grant_count 0, flags cleared; next state SEEK.
- SEEK (one tile examined per cycle):
  - given_mask[cursor]=0 -> GRANT.
  - given_mask[cursor]=1, dir FWD: cursor==AREA-1 -> DONE_OK; else cursor+1, stay.
  - given_mask[cursor]=1, dir BACK: cursor==0 -> DONE_FAIL; else cursor-1, stay.
- GRANT:
  - turn_valid=1 for exactly this cycle; turn_from_back = (dir==BACK).
  - grant_count+1, saturating.
  - If MAX_GRANTS!=0 and the incremented count == MAX_GRANTS -> DONE_FAIL with timed_out=1 (turn_valid still pulses this cycle). Else -> WAIT.
- WAIT: cursor held; waits indefinitely for tile_done=1.
  - pass_back=0: cursor==AREA-1 -> DONE_OK; else cursor+1, dir FWD, -> SEEK.
  - pass_back=1: cursor==0 -> DONE_FAIL; else cursor-1, dir BACK, -> SEEK.
- DONE_OK / DONE_FAIL:
  - Flags and cursor held.
  - start=1 -> same actions as start from IDLE; next state SEEK, flags drop in that cycle.
- start while busy: ignored.
- tile_done outside WAIT: ignored.
- tile_done in the same cycle as reset: reset wins.
- Latency:
  - start sampled at edge t -> SEEK at t+1.
  - First turn_valid at t+2 if tile 0 is not given; each consecutive given tile adds 1 cycle.
  - tile_done at edge w -> next turn_valid no earlier than w+2.
- done_success and done_failure are never both high. turn_valid is never high outside GRANT.

Test Plan:
1. ORDER=2, given_mask=0, tile_done/pass_back=0 each WAIT -> 16 turn_valid pulses, cursor 0..15, turn_from_back always 0; done_success one cycle after the 16th tile_done; grant_count=16.
2. ORDER=2, given_mask=16'hFFFF, start -> no turn_valid, done_success high 17 cycles after start (16 SEEK cycles), grant_count=0.
3. ORDER=2, given_mask bit1=1: tile0 forward, tile2 pass_back=1 -> next grant at cursor 0 with turn_from_back=1 (tile1 skipped); tile0 pass_back=1 -> done_failure=1, timed_out=0.
4. MAX_GRANTS=5, given_mask=0, alternate forward/back on tiles 0/1 -> 5th turn_valid then done_failure=1, timed_out=1, grant_count=5.
5. Reset asserted in WAIT at cursor 7 -> next cycle all outputs at reset values. start asserted during busy -> no effect. start in DONE_OK -> done_success drops and cursor returns to 0.
6. tile_done pulsed during SEEK/GRANT/IDLE -> cursor and state unaffected; only the WAIT-cycle pulse moves the cursor.
